// File: rtl/issue_scheduler_pkg.sv
// Shared definitions for the issue scheduler: slot-state encoding and index-width helper.
package issue_scheduler_pkg;

  // Encoded as {occ, iss}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    FREE   = 2'b00,
    WAIT   = 2'b10,
    ISSUED = 2'b11
  } slot_state_e;

  function automatic int calc_iw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/issue_scheduler_rr_pick.sv
// Round-robin picker: first set bit of req at or after start, wrapping modulo bs.
module rr_pick
  import issue_scheduler_pkg::*;
#(
  parameter int bs = 16,
  localparam int IW = calc_iw(bs)
) (
  input  logic [bs-1:0] req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] index
);

  logic [bs-1:0] rotated;
  logic [IW-1:0] offset;

  // Rotate so start lands at bit 0, then take the lowest set bit.
  always_comb begin
    rotated = '0;
    for (int i = 0; i < bs; i++) begin
      rotated[i] = req[start + IW'(i)];
    end
    found  = |rotated;
    offset = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      if (rotated[i]) offset = IW'(i);
    end
    index = start + offset;
  end

endmodule

// File: rtl/issue_scheduler.sv
// Issue scheduler: tracks slot state, issues ready slots round-robin, retires completions
// and requests refills of freed slots from fetch.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int bs = 16,
  localparam int IW = calc_iw(bs)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [0:bs-1] independent_instr,
  output logic          issue_valid,
  output logic [IW-1:0] issue_index,
  input  logic          issue_ready,
  input  logic          done_valid,
  input  logic [IW-1:0] done_index,
  output logic          fill_valid,
  output logic [IW-1:0] fill_index,
  input  logic          fill_ready,
  output logic [IW:0]   occupancy,
  output logic          err
);

  logic [bs-1:0] occ_q, occ_d, iss_q, iss_d;
  logic [bs-1:0] fill_req, issue_req;
  logic [IW-1:0] issue_ptr_q, issue_ptr_d, fill_ptr_q, fill_ptr_d;
  logic [IW-1:0] issue_index_q, issue_index_d, fill_index_q, fill_index_d;
  logic          issue_valid_q, issue_valid_d, fill_valid_q, fill_valid_d;
  logic          err_q, err_d;
  logic [IW:0]   occupancy_q, occupancy_d;
  logic          fill_found, issue_found, done_ok;
  logic [IW-1:0] fill_pick, issue_pick;
  slot_state_e   st;

  always_comb begin
    fill_req  = '0;
    issue_req = '0;
    st        = FREE;
    for (int i = 0; i < bs; i++) begin
      st           = slot_state_e'({occ_q[i], iss_q[i]});
      fill_req[i]  = (st == FREE);
      issue_req[i] = (st == WAIT) && independent_instr[i];
    end
  end

  rr_pick #(.bs(bs)) u_fill_pick (
    .req   (fill_req),
    .start (fill_ptr_q),
    .found (fill_found),
    .index (fill_pick)
  );

  rr_pick #(.bs(bs)) u_issue_pick (
    .req   (issue_req),
    .start (issue_ptr_q),
    .found (issue_found),
    .index (issue_pick)
  );

  // A done for the slot being issued this cycle sees it still WAIT, so it is flagged.
  always_comb begin
    occ_d         = occ_q;
    iss_d         = iss_q;
    fill_ptr_d    = fill_ptr_q;
    fill_valid_d  = fill_valid_q;
    fill_index_d  = fill_index_q;
    issue_ptr_d   = issue_ptr_q;
    issue_valid_d = issue_valid_q;
    issue_index_d = issue_index_q;
    done_ok       = done_valid &&
                    (slot_state_e'({occ_q[done_index], iss_q[done_index]}) == ISSUED);
    err_d         = err_q | (done_valid & ~done_ok);

    if (fill_valid_q) begin
      if (fill_ready) begin
        occ_d[fill_index_q] = 1'b1;
        fill_ptr_d          = fill_index_q + 1'b1;
        fill_valid_d        = 1'b0;
      end
    end else if (fill_found) begin
      fill_valid_d = 1'b1;
      fill_index_d = fill_pick;
    end

    if (issue_valid_q) begin
      if (issue_ready) begin
        iss_d[issue_index_q] = 1'b1;
        issue_ptr_d          = issue_index_q + 1'b1;
        issue_valid_d        = 1'b0;
      end
    end else if (issue_found) begin
      issue_valid_d = 1'b1;
      issue_index_d = issue_pick;
    end

    if (done_ok) begin
      occ_d[done_index] = 1'b0;
      iss_d[done_index] = 1'b0;
    end

    occupancy_d = '0;
    for (int i = 0; i < bs; i++) begin
      occupancy_d = occupancy_d + (IW+1)'(occ_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q         <= '0;
      iss_q         <= '0;
      fill_ptr_q    <= '0;
      fill_valid_q  <= 1'b0;
      fill_index_q  <= '0;
      issue_ptr_q   <= '0;
      issue_valid_q <= 1'b0;
      issue_index_q <= '0;
      occupancy_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      occ_q         <= occ_d;
      iss_q         <= iss_d;
      fill_ptr_q    <= fill_ptr_d;
      fill_valid_q  <= fill_valid_d;
      fill_index_q  <= fill_index_d;
      issue_ptr_q   <= issue_ptr_d;
      issue_valid_q <= issue_valid_d;
      issue_index_q <= issue_index_d;
      occupancy_q   <= occupancy_d;
      err_q         <= err_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_index = issue_index_q;
  assign fill_valid  = fill_valid_q;
  assign fill_index  = fill_index_q;
  assign occupancy   = occupancy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler (bs=4): slot-level reference model plus directed literal checks.
module tb_issue_scheduler;

  localparam int BS = 4;
  localparam int IW = 2;
  localparam int S_FREE = 0;
  localparam int S_WAIT = 1;
  localparam int S_ISSUED = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [0:BS-1] independent_instr = '0;
  logic          issue_valid;
  logic [IW-1:0] issue_index;
  logic          issue_ready = 1'b0;
  logic          done_valid = 1'b0;
  logic [IW-1:0] done_index = '0;
  logic          fill_valid;
  logic [IW-1:0] fill_index;
  logic          fill_ready = 1'b0;
  logic [IW:0]   occupancy;
  logic          err;

  int tests_run = 0;
  int tests_failed = 0;
  bit checking = 1'b0;

  int m_state[BS];
  int m_ip = 0, m_fp = 0, m_ii = 0, m_fi = 0, m_occ = 0;
  bit m_iv = 1'b0, m_fv = 1'b0, m_err = 1'b0;

  always #5 clk = ~clk;

  issue_scheduler #(.bs(BS)) dut (
    .clk               (clk),
    .rst               (rst),
    .independent_instr (independent_instr),
    .issue_valid       (issue_valid),
    .issue_index       (issue_index),
    .issue_ready       (issue_ready),
    .done_valid        (done_valid),
    .done_index        (done_index),
    .fill_valid        (fill_valid),
    .fill_index        (fill_index),
    .fill_ready        (fill_ready),
    .occupancy         (occupancy),
    .err               (err)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per-slot state array with a linear wrap-around scan.
  always @(posedge clk) begin : model
    int ns[BS];
    int nip, nfp, nii, nfi, cnt, s;
    bit niv, nfv, nerr;
    if (rst) begin
      for (int k = 0; k < BS; k++) ns[k] = S_FREE;
      nip = 0; nfp = 0; nii = 0; nfi = 0;
      niv = 1'b0; nfv = 1'b0; nerr = 1'b0;
    end else begin
      ns = m_state;
      nip = m_ip; nfp = m_fp; nii = m_ii; nfi = m_fi;
      niv = m_iv; nfv = m_fv; nerr = m_err;
      if (m_fv) begin
        if (fill_ready) begin
          ns[m_fi] = S_WAIT;
          nfp = (m_fi + 1) % BS;
          nfv = 1'b0;
        end
      end else begin
        for (int k = 0; k < BS; k++) begin
          s = (m_fp + k) % BS;
          if (!nfv && m_state[s] == S_FREE) begin
            nfv = 1'b1;
            nfi = s;
          end
        end
      end
      if (m_iv) begin
        if (issue_ready) begin
          ns[m_ii] = S_ISSUED;
          nip = (m_ii + 1) % BS;
          niv = 1'b0;
        end
      end else begin
        for (int k = 0; k < BS; k++) begin
          s = (m_ip + k) % BS;
          if (!niv && m_state[s] == S_WAIT && independent_instr[s]) begin
            niv = 1'b1;
            nii = s;
          end
        end
      end
      if (done_valid) begin
        if (m_state[int'(done_index)] == S_ISSUED) ns[int'(done_index)] = S_FREE;
        else nerr = 1'b1;
      end
    end
    cnt = 0;
    for (int k = 0; k < BS; k++) if (ns[k] != S_FREE) cnt++;
    m_state <= ns;
    m_ip <= nip; m_fp <= nfp; m_ii <= nii; m_fi <= nfi;
    m_iv <= niv; m_fv <= nfv; m_err <= nerr; m_occ <= cnt;
  end

  always @(negedge clk) begin
    if (checking) begin
      cmp("model.issue_valid", 32'(issue_valid), 32'(m_iv));
      cmp("model.issue_index", 32'(issue_index), 32'(m_ii));
      cmp("model.fill_valid",  32'(fill_valid),  32'(m_fv));
      cmp("model.fill_index",  32'(fill_index),  32'(m_fi));
      cmp("model.occupancy",   32'(occupancy),   32'(m_occ));
      cmp("model.err",         32'(err),         32'(m_err));
    end
  end

  task automatic applyStimulus(input logic r, input logic [0:BS-1] ind, input logic ir,
                               input logic dv, input logic [IW-1:0] di, input logic fr);
    rst = r;
    independent_instr = ind;
    issue_ready = ir;
    done_valid = dv;
    done_index = di;
    fill_ready = fr;
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input int iv, input int ii, input int fv,
                             input int fi, input int occ, input int e);
    cmp({name, ".issue_valid"}, 32'(issue_valid), 32'(iv));
    cmp({name, ".issue_index"}, 32'(issue_index), 32'(ii));
    cmp({name, ".fill_valid"},  32'(fill_valid),  32'(fv));
    cmp({name, ".fill_index"},  32'(fill_index),  32'(fi));
    cmp({name, ".occupancy"},   32'(occupancy),   32'(occ));
    cmp({name, ".err"},         32'(err),         32'(e));
  endtask

  initial begin
    applyStimulus(1, 4'b0000, 0, 0, 0, 0);
    checkOutput("reset", 0, 0, 0, 0, 0, 0);
    checking = 1'b1;

    // Fill all four slots, one per two cycles.
    for (int k = 0; k < BS; k++) begin
      applyStimulus(0, 4'b0000, 0, 0, 0, 1);
      checkOutput($sformatf("fill%0d_req", k), 0, 0, 1, k, k, 0);
      applyStimulus(0, 4'b0000, 0, 0, 0, 1);
      checkOutput($sformatf("fill%0d_acc", k), 0, 0, 0, k, k + 1, 0);
    end
    applyStimulus(0, 4'b0000, 0, 0, 0, 1);
    checkOutput("full", 0, 0, 0, 3, 4, 0);

    // Issue all four in order.
    for (int k = 0; k < BS; k++) begin
      applyStimulus(0, 4'b1111, 1, 0, 0, 1);
      checkOutput($sformatf("issue%0d_req", k), 1, k, 0, 3, 4, 0);
      applyStimulus(0, 4'b1111, 1, 0, 0, 1);
      checkOutput($sformatf("issue%0d_acc", k), 0, k, 0, 3, 4, 0);
    end
    applyStimulus(0, 4'b1111, 1, 0, 0, 1);
    checkOutput("none_eligible", 0, 3, 0, 3, 4, 0);

    // Completion latency and refill of slot 1.
    applyStimulus(0, 4'b0000, 0, 1, 1, 0);
    checkOutput("done1", 0, 3, 0, 3, 3, 0);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0);
    checkOutput("refill1_req", 0, 3, 1, 1, 3, 0);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0);
    checkOutput("refill1_hold", 0, 3, 1, 1, 3, 0);
    applyStimulus(0, 4'b0000, 0, 0, 0, 1);
    checkOutput("refill1_acc", 0, 3, 0, 1, 4, 0);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0);
    checkOutput("slot1_dep", 0, 3, 0, 1, 4, 0);
    applyStimulus(0, 4'b0100, 0, 0, 0, 0);
    checkOutput("slot1_issue", 1, 1, 0, 1, 4, 0);
    applyStimulus(0, 4'b0100, 1, 0, 0, 0);
    checkOutput("slot1_acc", 0, 1, 0, 1, 4, 0);

    // Slot 2 presented and held while independence bits change.
    applyStimulus(0, 4'b0000, 0, 1, 2, 0);
    checkOutput("done2", 0, 1, 0, 1, 3, 0);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0);
    checkOutput("refill2_req", 0, 1, 1, 2, 3, 0);
    applyStimulus(0, 4'b0000, 0, 0, 0, 1);
    checkOutput("refill2_acc", 0, 1, 0, 2, 4, 0);
    applyStimulus(0, 4'b0010, 0, 0, 0, 0);
    checkOutput("slot2_issue", 1, 2, 0, 2, 4, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, (k % 2 == 0) ? 4'b0110 : 4'b0111, 0, 0, 0, 0);
      checkOutput($sformatf("hold%0d", k), 1, 2, 0, 2, 4, 0);
    end
    applyStimulus(0, 4'b0110, 1, 0, 0, 0);
    checkOutput("slot2_acc", 0, 2, 0, 2, 4, 0);

    // Done on a WAIT slot sets sticky err and leaves the slot alone.
    applyStimulus(0, 4'b0000, 0, 1, 3, 0);
    checkOutput("done3", 0, 2, 0, 2, 3, 0);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0);
    checkOutput("refill3_req", 0, 2, 1, 3, 3, 0);
    applyStimulus(0, 4'b0000, 0, 0, 0, 1);
    checkOutput("refill3_acc", 0, 2, 0, 3, 4, 0);
    applyStimulus(0, 4'b0000, 0, 1, 3, 0);
    checkOutput("err_wait", 0, 2, 0, 3, 4, 1);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0);
    checkOutput("err_sticky", 0, 2, 0, 3, 4, 1);
    applyStimulus(0, 4'b0001, 0, 0, 0, 0);
    checkOutput("slot3_still_wait", 1, 3, 0, 3, 4, 1);
    applyStimulus(1, 4'b0001, 0, 0, 0, 0);
    checkOutput("reset2", 0, 0, 0, 0, 0, 0);

    // Done in the same cycle as the issue of that slot, then reset mid-handshake.
    applyStimulus(0, 4'b0000, 0, 0, 0, 0);
    checkOutput("d_fill0_req", 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 4'b1000, 0, 0, 0, 1);
    checkOutput("d_fill0_acc", 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 4'b1000, 0, 0, 0, 0);
    checkOutput("d_both_valid", 1, 0, 1, 1, 1, 0);
    applyStimulus(0, 4'b1000, 1, 1, 0, 0);
    checkOutput("d_done_issue_same", 0, 0, 1, 1, 1, 1);
    applyStimulus(0, 4'b1000, 0, 0, 0, 1);
    checkOutput("d_fill1_acc", 0, 0, 0, 1, 2, 1);
    applyStimulus(0, 4'b0100, 0, 0, 0, 0);
    checkOutput("d_both_valid2", 1, 1, 1, 2, 2, 1);
    applyStimulus(1, 4'b0100, 0, 0, 0, 0);
    checkOutput("d_reset", 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0);
    checkOutput("d_first_fill", 0, 0, 1, 0, 0, 0);

    // Random traffic checked only by the model.
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 59) == 0), 4'($urandom), 1'($urandom),
                    ($urandom_range(0, 2) == 0), 2'($urandom), 1'($urandom));
    end

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
